// File: rtl/fb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// fb_mem_arbiter
//
// Two-port arbiter in front of the single framebuffer block-RAM port.
// Port 0 is the display scan-out reader (read-only, fixed priority).
// Port 1 is the fill-rect engine (read/write). It is protected from starvation:
// after STARVE_LIMIT consecutive lost cycles it is forced to win.
//
// Every accepted request becomes one RAM access in the following cycle.
// Reads return two cycles after acceptance on the port that issued them.
// A two-stage tag pipeline routes each return (valid + port id).
//
// Ports:
//   clk, rst_                 clock, synchronous active-low reset
//   p0_rts/p0_rtr/p0_addr     port 0 request handshake and word address
//   p0_rd_data/p0_rd_valid    port 0 read return
//   p1_rts/p1_rtr             port 1 request handshake
//   p1_op                     1 = write, 0 = read
//   p1_addr/p1_data/p1_wben   port 1 address, write data, byte enables
//   p1_rd_data/p1_rd_valid    port 1 read return
//   mem_en/mem_we/mem_addr/mem_wdata   registered RAM command
//   mem_rdata                 RAM read data, valid one cycle after mem_en
// -----------------------------------------------------------------------------
module fb_mem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst_,

    input  logic                    p0_rts,
    output logic                    p0_rtr,
    input  logic [ADDR_WIDTH-1:0]   p0_addr,
    output logic [DATA_WIDTH-1:0]   p0_rd_data,
    output logic                    p0_rd_valid,

    input  logic                    p1_rts,
    output logic                    p1_rtr,
    input  logic                    p1_op,
    input  logic [ADDR_WIDTH-1:0]   p1_addr,
    input  logic [DATA_WIDTH-1:0]   p1_data,
    input  logic [DATA_WIDTH/8-1:0] p1_wben,
    output logic [DATA_WIDTH-1:0]   p1_rd_data,
    output logic                    p1_rd_valid,

    output logic                    mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int         BE_WIDTH   = DATA_WIDTH / 8;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0]            starve_cnt;
    logic                  force1;
    logic                  grant0;
    logic                  grant1;
    logic                  xfer;

    // Command selected for the RAM in the next cycle.
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BE_WIDTH-1:0]   sel_we;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_is_read;
    logic                  sel_port;

    // Tag stage 1: travels alongside the RAM command (cycle N+1).
    // Tag stage 2 is the pair of rd_valid flops (cycle N+2).
    logic                  tag_valid;
    logic                  tag_port;

    // Port 1 wins when it is being starved out or when port 0 is idle.
    assign force1 = (starve_cnt == STARVE_MAX);
    assign grant1 = p1_rts & (force1 | ~p0_rts);
    assign grant0 = p0_rts & ~grant1;

    // Accept nothing while reset is asserted, so no access is queued
    // behind a reset edge.
    assign p0_rtr = grant0 & rst_;
    assign p1_rtr = grant1 & rst_;
    assign xfer   = p0_rtr | p1_rtr;

    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        sel_addr    = '0;
        sel_we      = '0;
        sel_wdata   = '0;
        sel_is_read = 1'b0;
        sel_port    = 1'b0;
        if (p1_rtr) begin
            sel_addr = p1_addr;
            sel_port = 1'b1;
            if (p1_op) begin
                // A write with all enables low still occupies the slot.
                sel_we    = p1_wben;
                sel_wdata = p1_data;
            end else begin
                sel_is_read = 1'b1;
            end
        end else if (p0_rtr) begin
            sel_addr    = p0_addr;
            sel_is_read = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            mem_en      <= 1'b0;
            mem_we      <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            tag_valid   <= 1'b0;
            tag_port    <= 1'b0;
            p0_rd_valid <= 1'b0;
            p1_rd_valid <= 1'b0;
            starve_cnt  <= '0;
        end else begin
            mem_en      <= xfer;
            mem_we      <= sel_we;
            mem_addr    <= sel_addr;
            mem_wdata   <= sel_wdata;

            tag_valid   <= sel_is_read;
            tag_port    <= sel_port;
            p0_rd_valid <= tag_valid & ~tag_port;
            p1_rd_valid <= tag_valid &  tag_port;

            // Count consecutive cycles in which port 1 asks and loses.
            if (p1_rts && !p1_rtr) begin
                if (starve_cnt != STARVE_MAX) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // The RAM presents read data in the same cycle the return strobe is high.
    assign p0_rd_data = p0_rd_valid ? mem_rdata : '0;
    assign p1_rd_data = p1_rd_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_mem_arbiter
//
// Self-checking bench for fb_mem_arbiter with a behavioural block RAM.
//   1. Reset state.
//   2. Directed cycle table: writes, byte enables, back-to-back reads,
//      alternating ports, zero-enable write.
//   3. Reset during an in-flight read, followed by a sustained two-port
//      contention run (starvation rotation).
//   4. Random traffic against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_fb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_;
    logic        p0_rts;
    logic        p0_rtr;
    logic [15:0] p0_addr;
    logic [31:0] p0_rd_data;
    logic        p0_rd_valid;
    logic        p1_rts;
    logic        p1_rtr;
    logic        p1_op;
    logic [15:0] p1_addr;
    logic [31:0] p1_data;
    logic [3:0]  p1_wben;
    logic [31:0] p1_rd_data;
    logic        p1_rd_valid;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    fb_mem_arbiter #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (32),
        .STARVE_LIMIT(8)
    ) dut (
        .clk        (clk),
        .rst_       (rst_),
        .p0_rts     (p0_rts),
        .p0_rtr     (p0_rtr),
        .p0_addr    (p0_addr),
        .p0_rd_data (p0_rd_data),
        .p0_rd_valid(p0_rd_valid),
        .p1_rts     (p1_rts),
        .p1_rtr     (p1_rtr),
        .p1_op      (p1_op),
        .p1_addr    (p1_addr),
        .p1_data    (p1_data),
        .p1_wben    (p1_wben),
        .p1_rd_data (p1_rd_data),
        .p1_rd_valid(p1_rd_valid),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Behavioural single-port block RAM with byte write enables.
    logic [31:0] ram [0:65535];

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= ram[mem_addr];
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic [15:0] a0, input logic r1,
                         input logic op, input logic [15:0] a1, input logic [31:0] d1,
                         input logic [3:0] wb);
        p0_rts  = r0;
        p0_addr = a0;
        p1_rts  = r1;
        p1_op   = op;
        p1_addr = a1;
        p1_data = d1;
        p1_wben = wb;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Directed cycle table: inputs for the cycle, then the outputs expected
    // in that same cycle. mem_addr/mem_wdata are compared only when mem_en
    // is expected high.
    typedef struct packed {
        logic        r0;
        logic [15:0] a0;
        logic        r1;
        logic        op;
        logic [15:0] a1;
        logic [31:0] d1;
        logic [3:0]  wb;
        logic        rtr0;
        logic        rtr1;
        logic        en;
        logic [3:0]  we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        v0;
        logic [31:0] rd0;
        logic        v1;
        logic [31:0] rd1;
    } vec_t;

    vec_t tbl[$];

    // Reference-model bookkeeping for the random phase, keyed by cycle.
    typedef struct packed {
        logic        en;
        logic [3:0]  we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } mexp_t;

    typedef struct packed {
        logic        v0;
        logic        v1;
        logic [31:0] data;
    } rexp_t;

    mexp_t       mq [int];
    rexp_t       rq [int];
    logic [31:0] ref_mem [0:15];

    initial begin
        vec_t  v;
        mexp_t me;
        rexp_t re;
        int    lost;
        bit    g0;
        bit    g1;
        bit    want1;

        for (int i = 0; i < 65536; i++) ram[i] = 32'h0;
        for (int i = 1; i <= 4; i++) ram[i] = 32'hC0DE_0000 | 32'(i);

        // ---------------- reset state ----------------
        rst_ = 1'b0;
        drive(1'b1, 16'h0005, 1'b1, 1'b1, 16'h0006, 32'hFFFF_FFFF, 4'hF);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset p0_rtr",      p0_rtr,      1'b0);
        check("reset p1_rtr",      p1_rtr,      1'b0);
        check("reset mem_en",      mem_en,      1'b0);
        check("reset mem_we",      mem_we,      4'h0);
        check("reset mem_addr",    mem_addr,    16'h0);
        check("reset mem_wdata",   mem_wdata,   32'h0);
        check("reset p0_rd_valid", p0_rd_valid, 1'b0);
        check("reset p1_rd_valid", p1_rd_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_ = 1'b1;

        // ---------------- directed table ----------------
        //                 r0 a0        r1 op a1        d1            wb      rtr0 rtr1 en we    addr      wdata         v0 rd0           v1 rd1
        tbl.push_back('{1'b0,16'h0000,1'b1,1'b1,16'h0010,32'hDEADBEEF,4'hF, 1'b0,1'b1,1'b0,4'h0,16'h0000,32'h00000000, 1'b0,32'h0,        1'b0,32'h0});
        tbl.push_back('{1'b0,16'h0000,1'b1,1'b1,16'h0020,32'h11223344,4'h5, 1'b0,1'b1,1'b1,4'hF,16'h0010,32'hDEADBEEF, 1'b0,32'h0,        1'b0,32'h0});
        tbl.push_back('{1'b0,16'h0000,1'b1,1'b0,16'h0020,32'h00000000,4'h0, 1'b0,1'b1,1'b1,4'h5,16'h0020,32'h11223344, 1'b0,32'h0,        1'b0,32'h0});
        tbl.push_back('{1'b0,16'h0000,1'b0,1'b0,16'h0000,32'h00000000,4'h0, 1'b0,1'b0,1'b1,4'h0,16'h0020,32'h00000000, 1'b0,32'h0,        1'b0,32'h0});
        tbl.push_back('{1'b1,16'h0001,1'b0,1'b0,16'h0000,32'h00000000,4'h0, 1'b1,1'b0,1'b0,4'h0,16'h0000,32'h00000000, 1'b0,32'h0,        1'b1,32'h00220044});
        tbl.push_back('{1'b1,16'h0002,1'b0,1'b0,16'h0000,32'h00000000,4'h0, 1'b1,1'b0,1'b1,4'h0,16'h0001,32'h00000000, 1'b0,32'h0,        1'b0,32'h0});
        tbl.push_back('{1'b1,16'h0003,1'b0,1'b0,16'h0000,32'h00000000,4'h0, 1'b1,1'b0,1'b1,4'h0,16'h0002,32'h00000000, 1'b1,32'hC0DE0001,1'b0,32'h0});
        tbl.push_back('{1'b1,16'h0004,1'b0,1'b0,16'h0000,32'h00000000,4'h0, 1'b1,1'b0,1'b1,4'h0,16'h0003,32'h00000000, 1'b1,32'hC0DE0002,1'b0,32'h0});
        tbl.push_back('{1'b0,16'h0000,1'b0,1'b0,16'h0000,32'h00000000,4'h0, 1'b0,1'b0,1'b1,4'h0,16'h0004,32'h00000000, 1'b1,32'hC0DE0003,1'b0,32'h0});
        tbl.push_back('{1'b0,16'h0000,1'b0,1'b0,16'h0000,32'h00000000,4'h0, 1'b0,1'b0,1'b0,4'h0,16'h0000,32'h00000000, 1'b1,32'hC0DE0004,1'b0,32'h0});
        tbl.push_back('{1'b0,16'h0000,1'b0,1'b0,16'h0000,32'h00000000,4'h0, 1'b0,1'b0,1'b0,4'h0,16'h0000,32'h00000000, 1'b0,32'h0,        1'b0,32'h0});
        tbl.push_back('{1'b1,16'h0001,1'b0,1'b0,16'h0000,32'h00000000,4'h0, 1'b1,1'b0,1'b0,4'h0,16'h0000,32'h00000000, 1'b0,32'h0,        1'b0,32'h0});
        tbl.push_back('{1'b0,16'h0000,1'b1,1'b0,16'h0010,32'h00000000,4'h0, 1'b0,1'b1,1'b1,4'h0,16'h0001,32'h00000000, 1'b0,32'h0,        1'b0,32'h0});
        tbl.push_back('{1'b1,16'h0003,1'b0,1'b0,16'h0000,32'h00000000,4'h0, 1'b1,1'b0,1'b1,4'h0,16'h0010,32'h00000000, 1'b1,32'hC0DE0001,1'b0,32'h0});
        tbl.push_back('{1'b0,16'h0000,1'b1,1'b0,16'h0020,32'h00000000,4'h0, 1'b0,1'b1,1'b1,4'h0,16'h0003,32'h00000000, 1'b0,32'h0,        1'b1,32'hDEADBEEF});
        tbl.push_back('{1'b0,16'h0000,1'b0,1'b0,16'h0000,32'h00000000,4'h0, 1'b0,1'b0,1'b1,4'h0,16'h0020,32'h00000000, 1'b1,32'hC0DE0003,1'b0,32'h0});
        tbl.push_back('{1'b0,16'h0000,1'b0,1'b0,16'h0000,32'h00000000,4'h0, 1'b0,1'b0,1'b0,4'h0,16'h0000,32'h00000000, 1'b0,32'h0,        1'b1,32'h00220044});
        tbl.push_back('{1'b0,16'h0000,1'b1,1'b1,16'h0001,32'hFFFFFFFF,4'h0, 1'b0,1'b1,1'b0,4'h0,16'h0000,32'h00000000, 1'b0,32'h0,        1'b0,32'h0});
        tbl.push_back('{1'b0,16'h0000,1'b1,1'b0,16'h0001,32'h00000000,4'h0, 1'b0,1'b1,1'b1,4'h0,16'h0001,32'hFFFFFFFF, 1'b0,32'h0,        1'b0,32'h0});
        tbl.push_back('{1'b0,16'h0000,1'b0,1'b0,16'h0000,32'h00000000,4'h0, 1'b0,1'b0,1'b1,4'h0,16'h0001,32'h00000000, 1'b0,32'h0,        1'b0,32'h0});
        tbl.push_back('{1'b0,16'h0000,1'b0,1'b0,16'h0000,32'h00000000,4'h0, 1'b0,1'b0,1'b0,4'h0,16'h0000,32'h00000000, 1'b0,32'h0,        1'b1,32'hC0DE0001});
        tbl.push_back('{1'b0,16'h0000,1'b0,1'b0,16'h0000,32'h00000000,4'h0, 1'b0,1'b0,1'b0,4'h0,16'h0000,32'h00000000, 1'b0,32'h0,        1'b0,32'h0});

        foreach (tbl[i]) begin
            v = tbl[i];
            drive(v.r0, v.a0, v.r1, v.op, v.a1, v.d1, v.wb);
            @(negedge clk);
            check($sformatf("tbl[%0d] p0_rtr", i),      p0_rtr,      v.rtr0);
            check($sformatf("tbl[%0d] p1_rtr", i),      p1_rtr,      v.rtr1);
            check($sformatf("tbl[%0d] mem_en", i),      mem_en,      v.en);
            check($sformatf("tbl[%0d] mem_we", i),      mem_we,      v.we);
            if (v.en) begin
                check($sformatf("tbl[%0d] mem_addr", i),  mem_addr,  v.addr);
                check($sformatf("tbl[%0d] mem_wdata", i), mem_wdata, v.wdata);
            end
            check($sformatf("tbl[%0d] p0_rd_valid", i), p0_rd_valid, v.v0);
            check($sformatf("tbl[%0d] p0_rd_data", i),  p0_rd_data,  v.rd0);
            check($sformatf("tbl[%0d] p1_rd_valid", i), p1_rd_valid, v.v1);
            check($sformatf("tbl[%0d] p1_rd_data", i),  p1_rd_data,  v.rd1);
            next_cycle();
        end

        // ---------------- reset with a read in flight ----------------
        // Three contended cycles: port 0 wins each, port 1 accumulates lost
        // cycles, and the last port 0 read is still in the pipeline when
        // reset hits.
        drive(1'b1, 16'h0002, 1'b1, 1'b0, 16'h0003, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("pre-reset p0_rtr", p0_rtr, 1'b1);
            check("pre-reset p1_rtr", p1_rtr, 1'b0);
            next_cycle();
        end
        rst_ = 1'b0;
        @(negedge clk);
        check("in-reset p0_rtr", p0_rtr, 1'b0);
        check("in-reset p1_rtr", p1_rtr, 1'b0);
        next_cycle();
        rst_ = 1'b1;

        // Sustained contention straight out of reset: with the lost-cycle
        // count cleared, port 0 wins 8 cycles and port 1 the 9th, repeating.
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("post-reset mem_en",      mem_en,      1'b0);
                check("post-reset p0_rd_valid", p0_rd_valid, 1'b0);
                check("post-reset p1_rd_valid", p1_rd_valid, 1'b0);
            end
            if (i == 1) begin
                check("flush p0_rd_valid", p0_rd_valid, 1'b0);
                check("flush p1_rd_valid", p1_rd_valid, 1'b0);
            end
            want1 = ((i % 9) == 8);
            check($sformatf("starve[%0d] p1_rtr", i), p1_rtr, want1);
            check($sformatf("starve[%0d] p0_rtr", i), p0_rtr, !want1);
            check($sformatf("starve[%0d] one-hot", i), 32'(p0_rtr) + 32'(p1_rtr), 32'd1);
            next_cycle();
        end

        // ---------------- random traffic vs reference model ----------------
        idle();
        next_cycle();
        next_cycle();
        next_cycle();
        rst_ = 1'b0;
        next_cycle();
        rst_ = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            ram[i]     = ref_mem[i];
        end
        lost = 0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc < 596) begin
                drive($urandom_range(0, 9) < 7, 16'($urandom_range(0, 15)),
                      $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                      16'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            end else begin
                idle();
            end

            // Priority rule with starvation override.
            g1 = p1_rts && (lost == 8 || !p0_rts);
            g0 = p0_rts && !g1;

            @(negedge clk);
            me = mq.exists(cyc) ? mq[cyc] : '0;
            re = rq.exists(cyc) ? rq[cyc] : '0;
            check("rnd p0_rtr", p0_rtr, g0);
            check("rnd p1_rtr", p1_rtr, g1);
            check("rnd mem_en", mem_en, me.en);
            check("rnd mem_we", mem_we, me.we);
            if (me.en) begin
                check("rnd mem_addr",  mem_addr,  me.addr);
                check("rnd mem_wdata", mem_wdata, me.wdata);
            end
            check("rnd p0_rd_valid", p0_rd_valid, re.v0);
            check("rnd p0_rd_data",  p0_rd_data,  re.v0 ? re.data : 32'h0);
            check("rnd p1_rd_valid", p1_rd_valid, re.v1);
            check("rnd p1_rd_data",  p1_rd_data,  re.v1 ? re.data : 32'h0);

            // Schedule the consequences of this cycle's transfer. Accesses
            // execute in acceptance order, so a read returns the shadow
            // memory contents as of its acceptance.
            if (g0) begin
                mq[cyc+1] = '{1'b1, 4'h0, p0_addr, 32'h0};
                rq[cyc+2] = '{1'b1, 1'b0, ref_mem[p0_addr[3:0]]};
            end else if (g1 && p1_op) begin
                mq[cyc+1] = '{1'b1, p1_wben, p1_addr, p1_data};
                for (int b = 0; b < 4; b++) begin
                    if (p1_wben[b]) ref_mem[p1_addr[3:0]][8*b +: 8] = p1_data[8*b +: 8];
                end
            end else if (g1) begin
                mq[cyc+1] = '{1'b1, 4'h0, p1_addr, 32'h0};
                rq[cyc+2] = '{1'b0, 1'b1, ref_mem[p1_addr[3:0]]};
            end

            if (p1_rts && !g1) lost = (lost < 8) ? lost + 1 : 8;
            else               lost = 0;

            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
- Sits directly downstream of the fill-rect engine's arbiter interface and of the display scan-out reader.
- Arbitrates their requests onto the single framebuffer block-RAM port: 16-bit word address, 32-bit data, 4-bit byte write enables.
- Returns read data to the requester that issued the read.
- Port 0 (display) has priority; port 1 (fill engine) is protected from starvation by a counter.

Parameters:
- ADDR_WIDTH, 16, word address width on all ports.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- STARVE_LIMIT, 8, consecutive lost arbitration cycles after which port 1 is forced to win.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_  in  1  synchronous active-low reset.
- p0_rts  in  1  port 0 (display) request valid.
- p0_rtr  out  1  port 0 request accepted this cycle.
- p0_addr  in  16  port 0 word address (read-only port).
- p0_rd_data  out  32  port 0 read return data.
- p0_rd_valid  out  1  port 0 read return strobe.
- p1_rts  in  1  port 1 (fill engine) request valid.
- p1_rtr  out  1  port 1 request accepted this cycle.
- p1_op  in  1  1 = write, 0 = read.
- p1_addr  in  16  port 1 word address.
- p1_data  in  32  port 1 write data.
- p1_wben  in  4  port 1 byte write enables; bit i covers data[8i+7:8i].
- p1_rd_data  out  32  port 1 read return data.
- p1_rd_valid  out  1  port 1 read return strobe.
- mem_en  out  1  RAM access enable.
- mem_we  out  4  RAM byte write enables; 0 for reads.
- mem_addr  out  16  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid one cycle after mem_en.

Behaviour:
- Reset (rst_ low at a clock edge):
  - Every registered output clears to 0: mem_en, mem_we, mem_addr, mem_wdata, p0_rd_valid, p1_rd_valid.
  - starve_cnt clears to 0.
  - The in-flight read pipeline is flushed: a read accepted before reset never produces rd_valid.
  - p0_rtr and p1_rtr are 0 whenever rst_ is low.
- Transfer rule: a request on port k transfers in a cycle when pk_rts and pk_rtr are both high.
- Grant selection is combinational from the current rts values and the registered starve flag:
  - force1 = (starve_cnt == STARVE_LIMIT).
  - grant1 = p1_rts and (force1 or not p0_rts).
  - grant0 = p0_rts and not grant1.
  - pk_rtr = grant_k and rst_.
  - At most one rtr is high in any cycle.
  - No rts means no rtr and no access.
- Starvation counter starve_cnt, 4 bits:
  - Increments when p1_rts is high and p1 is not granted.
  - Clears to 0 when p1 is granted or p1_rts is low.
  - Saturates at STARVE_LIMIT.
- Pipeline, for a transfer in cycle N:
  - Cycle N+1: mem_en = 1; mem_addr = the granted address.
  - Cycle N+1, writes: mem_we = p1_wben and mem_wdata = p1_data.
  - Cycle N+1, reads: mem_we = 0 and mem_wdata = 0.
  - Cycle N+2 (reads only): pk_rd_valid = 1 and pk_rd_data = mem_rdata, taken combinationally from the RAM.
  - rd_data is 0 whenever rd_valid is low.
- With no transfer in cycle N, mem_en = 0 and mem_we = 0 in N+1.
- A 2-stage tag shift register (valid bit + port id) routes returns.
- Throughput: one access per cycle, back-to-back.
- Read returns have no backpressure; requesters must absorb one return per cycle.
- Writes followed by reads to the same address in the next cycle return the new data, because the RAM commits the write before the later read.
- A port 1 write with p1_wben = 0 still consumes a slot, with mem_en = 1 and mem_we = 0.

Test Plan:
- Reset, then p1 writes addr 0x0010, data 0xDEADBEEF, wben 0xF -> p1_rtr = 1 in N; in N+1 mem_en = 1, mem_we = 0xF, mem_addr = 0x0010, mem_wdata = 0xDEADBEEF.
- p1 write 0x0020 = 0x11223344 with wben 0x5, then p1 read 0x0020 -> mem_we = 0x5; p1_rd_valid 2 cycles after the read accept; p1_rd_data = 0x00220044 (RAM preloaded with 0).
- p0 reads 0x0001..0x0004 back-to-back -> p0_rtr high 4 cycles; p0_rd_valid high 4 consecutive cycles starting 2 after the first accept; data in address order; p1_rd_valid stays 0.
- p0_rts and p1_rts held high continuously -> p0 wins 8 cycles, p1 wins the 9th, then the pattern repeats (STARVE_LIMIT = 8); never both rtr high.
- p0 read accepted, then rst_ low for 1 cycle on the next edge -> no rd_valid on either port; mem_en = 0 after reset; starve_cnt = 0.
- Alternating p0 read / p1 read every cycle -> each rd_valid pulses on the correct port with matching data; no cross-routing.
